uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one UART transmitter between NUM_REQ byte producers.
- Each producer raises a level request with its byte.
- The block picks one producer, captures the byte and acknowledges it. It pulses the transmitter start, then tracks the transmitter through busy/done.
- It inserts a programmable idle gap between frames and recovers from a transmitter that never starts.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width per requester.
- GAP_CLKS, 16, idle clocks inserted after each frame (0 allowed = no gap).
- TIMEOUT_CLKS, 1024, max clocks to wait for tx_busy after tx_start before abandoning the frame (>=2).

Ports:
- tx_clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- req  input  NUM_REQ  per-requester level request, held until its ack.
- req_data  input  NUM_REQ*DATA_W  byte for requester i at bits [i*DATA_W +: DATA_W].
- ack  output  NUM_REQ  one-hot, one-cycle pulse: requester's byte captured.
- grant_id  output  clog2(NUM_REQ)  index of the last granted requester.
- tx_start  output  1  one-cycle start pulse to the transmitter.
- tx_data  output  DATA_W  byte for the transmitter, held stable until the next grant.
- tx_busy  input  1  transmitter frame in progress.
- tx_done  input  1  transmitter one-cycle end-of-frame pulse.
- arb_busy  output  1  high whenever state != IDLE.
- err_timeout  output  1  one-cycle pulse when a frame is abandoned.

Behaviour:
- Reset (rst_n low at an edge):
  - state=IDLE; ack=0, tx_start=0, err_timeout=0, arb_busy=0, tx_data=0, grant_id=0.
  - Counters=0; round-robin pointer last=NUM_REQ-1, so requester 0 has top priority.
  - Reset mid-frame does not cancel the transmitter. After reset the block simply waits in IDLE for tx_busy=0.
- States (2-bit): IDLE, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE:
  - Grant when (|req) and tx_busy=0. Winner = first asserted req scanning last+1, last+2, ... modulo NUM_REQ.
  - On that edge, all registered:
    - ack<=onehot(winner), tx_start<=1.
    - tx_data<=req_data[winner], grant_id<=winner, last<=winner.
    - cnt<=0, state<=WAIT_BUSY.
  - Otherwise stay in IDLE.
- Latency: req sampled high at edge E in IDLE → ack, tx_start, tx_data and grant_id all valid in the cycle after E.
- WAIT_BUSY:
  - tx_done=1 → GAP. This takes priority, covering frames shorter than the observation window.
  - Else tx_busy=1 → WAIT_DONE.
  - Else if cnt==TIMEOUT_CLKS-1 → err_timeout<=1 for one cycle, state<=GAP.
  - Else cnt<=cnt+1.
- WAIT_DONE:
  - tx_done=1 → GAP.
  - There is no timeout here; the transmitter guarantees frame termination.
- GAP:
  - Entering GAP loads cnt<=0.
  - Leave to IDLE when cnt==GAP_CLKS-1; else increment.
  - With GAP_CLKS=0, WAIT_BUSY/WAIT_DONE go directly to IDLE instead of GAP.
- ack and tx_start are high for exactly one cycle per grant and are never asserted outside the IDLE→WAIT_BUSY transition.
- Requesters deassert req on seeing ack. Because IDLE is not re-entered for at least 2 cycles after ack, a one-cycle late deassert never causes a duplicate grant.
- A req dropped before grant is simply not considered; there is no latching of requests.
- Simultaneous requests are resolved by round-robin only; no requester can be granted twice while another asserted requester waits.
- Counter width is clog2(max(TIMEOUT_CLKS, GAP_CLKS)+1); counters never wrap.
- req_data of non-winners is ignored. tx_data changes only on a grant edge or reset.

Test Plan:
- Single request: req=4'b0100, req_data[2]=8'hA5, TX model raises busy 3 clks after start, done 20 clks later → ack=4'b0100, tx_start=1 and tx_data=8'hA5, grant_id=2 one cycle after req. arb_busy is high from that cycle until 16 clks after tx_done. No second ack.
- Four requesters held continuously with bytes 11,22,33,44 → grant order 0,1,2,3,0,1. The byte sequence on tx_data at each tx_start matches. Consecutive tx_start pulses are never closer than frame length + 16 clks.
- Requesters 0 and 2 held continuously → grant order 0,2,0,2; requesters 1 and 3 are never acked.
- tx_busy and tx_done stuck 0, req=4'b0001 → err_timeout pulses exactly 1024 clks after tx_start, then 16 gap clks. With req=4'b0011 held, the next grant goes to requester 1.
- tx_busy=1 when reset releases, req=4'b1000 → no ack or tx_start until tx_busy falls. Grant occurs in the cycle after the first edge sampling tx_busy=0.
- Reset asserted for one edge while in WAIT_DONE → all outputs 0 in the next cycle and state IDLE. A subsequent req=4'b1001 grants requester 0 first.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Bundle of the requester-side and transmitter-side signals of the UART
// transmit arbiter. The arbiter takes the master view; the producers and
// the transmitter together form the slave view.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) ();

  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;
  logic [ID_W-1:0]           grant_id;
  logic                      tx_start;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_busy;
  logic                      tx_done;
  logic                      arb_busy;
  logic                      err_timeout;

  modport master (
    input  req, req_data, tx_busy, tx_done,
    output ack, grant_id, tx_start, tx_data, arb_busy, err_timeout
  );

  modport slave (
    output req, req_data, tx_busy, tx_done,
    input  ack, grant_id, tx_start, tx_data, arb_busy, err_timeout
  );

endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte
// producers. A winner's byte is captured and acknowledged, the transmitter
// is started, then followed through busy/done. An idle gap separates frames
// and a transmitter that never reports busy is abandoned after a timeout.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int GAP_CLKS     = 16,
  parameter int TIMEOUT_CLKS = 1024
) (
  input  logic              tx_clk,
  input  logic              rst_n,
  uart_tx_arbiter_if.master bus
);

  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int CNT_MAX = (TIMEOUT_CLKS > GAP_CLKS) ? TIMEOUT_CLKS : GAP_CLKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Terminal counts; the gap value is only used when GAP_CLKS > 0.
  localparam logic [CNT_W-1:0] TO_LAST_C  = CNT_W'(TIMEOUT_CLKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST_C = CNT_W'((GAP_CLKS > 0) ? (GAP_CLKS - 1) : 0);
  // Pointer starts at the top index so requester 0 is scanned first.
  localparam logic [ID_W-1:0]  LAST_RST_C = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } state_t;

  // With no gap configured a finished frame goes straight back to IDLE.
  localparam state_t FRAME_END_ST = (GAP_CLKS > 0) ? ST_GAP : ST_IDLE;

  // Round-robin pick: first asserted request at last+1, last+2, ... modulo
  // NUM_REQ. Scanning from the farthest offset down lets the nearest win.
  // Result MSB flags that any request was found.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                            input logic [ID_W-1:0]    last);
    logic [ID_W:0] res;
    int            idx;
    res = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = (int'(last) + off) % NUM_REQ;
      res = r[idx[ID_W-1:0]] ? {1'b1, idx[ID_W-1:0]} : res;
    end
    return res;
  endfunction

  // Byte of requester id out of the packed request data bus.
  function automatic logic [DATA_W-1:0] byte_sel(input logic [NUM_REQ*DATA_W-1:0] d,
                                                 input logic [ID_W-1:0]          id);
    logic [DATA_W-1:0] res;
    res = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      res = (id == ID_W'(i)) ? d[i*DATA_W +: DATA_W] : res;
    end
    return res;
  endfunction

  // One-hot vector for requester id.
  function automatic logic [NUM_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
    logic [NUM_REQ-1:0] res;
    res = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      res[i] = (id == ID_W'(i));
    end
    return res;
  endfunction

  state_t             state_r,       state_nxt_s;
  logic [CNT_W-1:0]   cnt_r,         cnt_nxt_s;
  logic [ID_W-1:0]    last_r,        last_nxt_s;
  logic [ID_W-1:0]    grant_id_r,    grant_id_nxt_s;
  logic [NUM_REQ-1:0] ack_r,         ack_nxt_s;
  logic               tx_start_r,    tx_start_nxt_s;
  logic               err_timeout_r, err_timeout_nxt_s;
  logic               arb_busy_r,    arb_busy_nxt_s;
  logic [DATA_W-1:0]  tx_data_r,     tx_data_nxt_s;

  logic [ID_W:0]      pick_s;
  logic [ID_W-1:0]    win_id_s;
  logic               grant_ok_s;

  // A grant needs a pending request and an idle transmitter; the latter also
  // covers a frame left running across a reset.
  assign pick_s     = rr_pick(bus.req, last_r);
  assign win_id_s   = pick_s[ID_W-1:0];
  assign grant_ok_s = pick_s[ID_W] & ~bus.tx_busy;

  // Next-state and next-output logic of the arbitration FSM.
  always_comb begin
    state_nxt_s       = state_r;
    cnt_nxt_s         = cnt_r;
    last_nxt_s        = last_r;
    grant_id_nxt_s    = grant_id_r;
    tx_data_nxt_s     = tx_data_r;
    ack_nxt_s         = '0;
    tx_start_nxt_s    = 1'b0;
    err_timeout_nxt_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (grant_ok_s) begin
          ack_nxt_s      = id_onehot(win_id_s);
          tx_start_nxt_s = 1'b1;
          tx_data_nxt_s  = byte_sel(bus.req_data, win_id_s);
          grant_id_nxt_s = win_id_s;
          last_nxt_s     = win_id_s;
          cnt_nxt_s      = '0;
          state_nxt_s    = ST_WAIT_BUSY;
        end else begin
          state_nxt_s    = ST_IDLE;
        end
      end

      ST_WAIT_BUSY: begin
        // done wins over busy: a frame may finish before busy is ever seen
        if (bus.tx_done) begin
          state_nxt_s       = FRAME_END_ST;
          cnt_nxt_s         = '0;
        end else if (bus.tx_busy) begin
          state_nxt_s       = ST_WAIT_DONE;
        end else if (cnt_r == TO_LAST_C) begin
          err_timeout_nxt_s = 1'b1;
          state_nxt_s       = FRAME_END_ST;
          cnt_nxt_s         = '0;
        end else begin
          cnt_nxt_s         = cnt_r + CNT_W'(1);
        end
      end

      ST_WAIT_DONE: begin
        // the transmitter always terminates a started frame
        if (bus.tx_done) begin
          state_nxt_s = FRAME_END_ST;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = ST_WAIT_DONE;
        end
      end

      ST_GAP: begin
        if (cnt_r == GAP_LAST_C) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = '0;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_W'(1);
        end
      end

      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = '0;
      end
    endcase

    arb_busy_nxt_s = (state_nxt_s != ST_IDLE);
  end

  // State, counter, pointer and all outputs registered; synchronous reset.
  always_ff @(posedge tx_clk) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      cnt_r         <= '0;
      last_r        <= LAST_RST_C;
      grant_id_r    <= '0;
      tx_data_r     <= '0;
      ack_r         <= '0;
      tx_start_r    <= 1'b0;
      err_timeout_r <= 1'b0;
      arb_busy_r    <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      cnt_r         <= cnt_nxt_s;
      last_r        <= last_nxt_s;
      grant_id_r    <= grant_id_nxt_s;
      tx_data_r     <= tx_data_nxt_s;
      ack_r         <= ack_nxt_s;
      tx_start_r    <= tx_start_nxt_s;
      err_timeout_r <= err_timeout_nxt_s;
      arb_busy_r    <= arb_busy_nxt_s;
    end
  end

  assign bus.ack         = ack_r;
  assign bus.grant_id    = grant_id_r;
  assign bus.tx_start    = tx_start_r;
  assign bus.tx_data     = tx_data_r;
  assign bus.arb_busy    = arb_busy_r;
  assign bus.err_timeout = err_timeout_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: table of single-grant vectors, hand-written
// multi-cycle sequences and a randomized run, all cross-checked every cycle
// against a timestamp-based reference model of the arbitration rules.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int GAP = 16;
  localparam int TO  = 1024;

  logic tx_clk;
  logic rst_n;

  uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus_if ();

  uart_tx_arbiter #(
    .NUM_REQ(N), .DATA_W(W), .GAP_CLKS(GAP), .TIMEOUT_CLKS(TO)
  ) dut (
    .tx_clk(tx_clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial begin
    tx_clk = 1'b0;
    forever #5 tx_clk = ~tx_clk;
  end

  int errors = 0;
  int checks = 0;

  // Reference model: phase 0 idle, 1 started/awaiting busy, 2 busy, 3 gap.
  int           cyc    = 0;
  int           ph     = 0;
  int           t_g    = 0;
  int           t_e    = 0;
  int           m_last = N - 1;
  logic [N-1:0] e_ack  = '0;
  logic         e_start = 1'b0;
  logic         e_err   = 1'b0;
  logic [W-1:0] e_data  = '0;
  logic [1:0]   e_gid   = '0;

  // Environment: requesters and a transmitter model.
  bit auto_drop  = 1'b0;
  bit rand_mode  = 1'b0;
  bit tx_dead    = 1'b0;
  bit force_busy = 1'b0;
  bit tm_active  = 1'b0;
  int tm_cnt = 0, tm_bd = 3, tm_len = 20;
  int cfg_bd = 3, cfg_len = 20;

  // Grant recorder
  int         rec_n;
  int         rec_gid [8];
  logic [7:0] rec_byte[8];
  int         rec_t   [8];

  typedef struct {
    logic [N-1:0]   req;
    logic [N*W-1:0] data;
    logic [N-1:0]   exp_ack;
    logic [1:0]     exp_gid;
    logic [W-1:0]   exp_byte;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Apply the arbitration rules to the inputs present at this rising edge.
  task automatic model_step();
    int win;
    int idx;
    cyc++;
    if (!rst_n) begin
      ph = 0; m_last = N - 1;
      e_ack = '0; e_start = 1'b0; e_err = 1'b0; e_data = '0; e_gid = '0;
    end else begin
      e_ack = '0; e_start = 1'b0; e_err = 1'b0;
      case (ph)
        0: if (bus_if.req != '0 && !bus_if.tx_busy) begin
             win = -1;
             for (int k = 1; k <= N; k++) begin
               idx = (m_last + k) % N;
               if (win < 0 && ((bus_if.req >> idx) & 4'd1) != 4'd0) win = idx;
             end
             e_ack   = 4'd1 << win;
             e_start = 1'b1;
             e_data  = W'(bus_if.req_data >> (win * W));
             e_gid   = 2'(win);
             m_last  = win;
             t_g     = cyc;
             ph      = 1;
           end
        1: if (bus_if.tx_done) begin
             t_e = cyc; ph = (GAP == 0) ? 0 : 3;
           end else if (bus_if.tx_busy) begin
             ph = 2;
           end else if (cyc - t_g == TO) begin
             e_err = 1'b1; t_e = cyc; ph = (GAP == 0) ? 0 : 3;
           end
        2: if (bus_if.tx_done) begin
             t_e = cyc; ph = (GAP == 0) ? 0 : 3;
           end
        3: if (cyc == t_e + GAP) ph = 0;
        default: ph = 0;
      endcase
    end
  endtask

  // One clock: model at the rising edge, compare and drive at the falling edge.
  task automatic tick();
    @(posedge tx_clk);
    model_step();
    @(negedge tx_clk);
    chk("m_ack",   32'(bus_if.ack),         32'(e_ack));
    chk("m_start", 32'(bus_if.tx_start),    32'(e_start));
    chk("m_err",   32'(bus_if.err_timeout), 32'(e_err));
    chk("m_busy",  32'(bus_if.arb_busy),    32'(ph != 0));
    chk("m_data",  32'(bus_if.tx_data),     32'(e_data));
    chk("m_gid",   32'(bus_if.grant_id),    32'(e_gid));
    if (auto_drop) bus_if.req = bus_if.req & ~bus_if.ack;
    if (bus_if.tx_start) begin
      tm_active = 1'b1; tm_cnt = 0;
      if (rand_mode) begin
        tm_bd = int'($urandom_range(1, 4)); tm_len = int'($urandom_range(0, 12));
      end else begin
        tm_bd = cfg_bd; tm_len = cfg_len;
      end
    end else if (tm_active) begin
      tm_cnt++;
    end
    bus_if.tx_busy = force_busy || (tm_active && !tx_dead && tm_cnt >= tm_bd && tm_cnt < tm_bd + tm_len);
    bus_if.tx_done = tm_active && !tx_dead && (tm_cnt == tm_bd + tm_len);
    if (tm_active && tm_cnt >= tm_bd + tm_len) tm_active = 1'b0;
    if (rand_mode) begin
      for (int i = 0; i < N; i++) begin
        if (!bus_if.req[i] && $urandom_range(0, 7) == 0) begin
          bus_if.req[i] = 1'b1;
          bus_if.req_data[i*W +: W] = W'($urandom);
        end else if (bus_if.req[i] && !bus_if.ack[i] && $urandom_range(0, 63) == 0) begin
          bus_if.req[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic do_reset(input bit clear_tx);
    rst_n = 1'b0;
    bus_if.req = '0;
    if (clear_tx) begin
      tm_active = 1'b0; bus_if.tx_busy = 1'b0; bus_if.tx_done = 1'b0;
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 300 && bus_if.arb_busy; n++) tick();
    chk("idle_bound", 32'(bus_if.arb_busy), 32'd0);
  endtask

  task automatic record_starts(input int n, input int budget);
    rec_n = 0;
    for (int k = 0; k < budget && rec_n < n; k++) begin
      tick();
      if (bus_if.tx_start) begin
        rec_gid[rec_n] = int'(bus_if.grant_id);
        rec_byte[rec_n] = bus_if.tx_data;
        rec_t[rec_n] = cyc;
        rec_n++;
      end
    end
    chk("start_count", 32'(rec_n), 32'(n));
  endtask

  initial begin
    int busy_cnt, acks, t0, t_err, hold, n;
    int eo4[6];
    int eo2[4];

    rst_n = 1'b0;
    bus_if.req = '0; bus_if.req_data = '0;
    bus_if.tx_busy = 1'b0; bus_if.tx_done = 1'b0;

    vecs[0] = '{req: 4'b0100, data: 32'h00A5_0000, exp_ack: 4'b0100, exp_gid: 2'd2, exp_byte: 8'hA5};
    vecs[1] = '{req: 4'b1010, data: 32'h7700_6600, exp_ack: 4'b0010, exp_gid: 2'd1, exp_byte: 8'h66};
    vecs[2] = '{req: 4'b1000, data: 32'hC300_0000, exp_ack: 4'b1000, exp_gid: 2'd3, exp_byte: 8'hC3};
    vecs[3] = '{req: 4'b1111, data: 32'h4433_2211, exp_ack: 4'b0001, exp_gid: 2'd0, exp_byte: 8'h11};
    vecs[4] = '{req: 4'b0001, data: 32'hDEAD_BE5A, exp_ack: 4'b0001, exp_gid: 2'd0, exp_byte: 8'h5A};

    // Reset state
    tick(); tick();
    chk("rst_ack",   32'(bus_if.ack),         32'd0);
    chk("rst_start", 32'(bus_if.tx_start),    32'd0);
    chk("rst_err",   32'(bus_if.err_timeout), 32'd0);
    chk("rst_busy",  32'(bus_if.arb_busy),    32'd0);
    chk("rst_data",  32'(bus_if.tx_data),     32'd0);
    chk("rst_gid",   32'(bus_if.grant_id),    32'd0);

    // Table: one grant from reset, then arb_busy length and no repeat ack
    for (int v = 0; v < 5; v++) begin
      do_reset(1'b1);
      auto_drop = 1'b0; cfg_bd = 3; cfg_len = 20;
      bus_if.req_data = vecs[v].data;
      bus_if.req = vecs[v].req;
      tick();
      chk($sformatf("row%0d_ack", v),   32'(bus_if.ack),      32'(vecs[v].exp_ack));
      chk($sformatf("row%0d_start", v), 32'(bus_if.tx_start), 32'd1);
      chk($sformatf("row%0d_data", v),  32'(bus_if.tx_data),  32'(vecs[v].exp_byte));
      chk($sformatf("row%0d_gid", v),   32'(bus_if.grant_id), 32'(vecs[v].exp_gid));
      bus_if.req = '0;
      busy_cnt = 1; acks = 0;
      for (int k = 0; k < 200 && bus_if.arb_busy; k++) begin
        tick();
        if (bus_if.arb_busy) busy_cnt++;
        if (bus_if.ack != '0) acks++;
      end
      for (int k = 0; k < 3; k++) begin
        tick();
        if (bus_if.ack != '0) acks++;
      end
      // start->done is bd+len+1 edges, then GAP edges back to idle
      chk($sformatf("row%0d_busy_len", v), 32'(busy_cnt), 32'(cfg_bd + cfg_len + 1 + GAP));
      chk($sformatf("row%0d_extra_ack", v), 32'(acks), 32'd0);
    end

    // Four requesters held: 0,1,2,3,0,1 with their bytes and fixed spacing
    do_reset(1'b1);
    eo4 = '{0, 1, 2, 3, 0, 1};
    bus_if.req_data = 32'h4433_2211;
    bus_if.req = 4'b1111;
    record_starts(6, 600);
    for (int i = 0; i < rec_n; i++) begin
      chk($sformatf("rr4_gid%0d", i),  32'(rec_gid[i]),  32'(eo4[i]));
      chk($sformatf("rr4_byte%0d", i), 32'(rec_byte[i]), 32'(8'h11 * (eo4[i] + 1)));
      if (i > 0) chk($sformatf("rr4_gap%0d", i), 32'(rec_t[i] - rec_t[i-1]), 32'(cfg_bd + cfg_len + GAP + 2));
    end
    bus_if.req = '0;
    wait_idle();

    // Requesters 0 and 2 held: alternate 0,2,0,2
    do_reset(1'b1);
    eo2 = '{0, 2, 0, 2};
    bus_if.req_data = 32'h00BB_00AA;
    bus_if.req = 4'b0101;
    record_starts(4, 400);
    for (int i = 0; i < rec_n; i++) begin
      chk($sformatf("rr2_gid%0d", i),  32'(rec_gid[i]),  32'(eo2[i]));
      chk($sformatf("rr2_byte%0d", i), 32'(rec_byte[i]), (eo2[i] == 0) ? 32'hAA : 32'hBB);
    end
    bus_if.req = '0;
    wait_idle();

    // Dead transmitter: timeout after TO clocks, gap, then requester 1
    do_reset(1'b1);
    tx_dead = 1'b1;
    bus_if.req_data = 32'h0000_2010;
    bus_if.req = 4'b0011;
    record_starts(1, 5);
    t0 = rec_t[0];
    chk("to_first_gid", 32'(rec_gid[0]), 32'd0);
    n = 0;
    for (n = 0; n < 1100; n++) begin
      tick();
      if (bus_if.err_timeout) break;
    end
    t_err = cyc;
    chk("to_dist", 32'(t_err - t0), 32'(TO));
    tick();
    chk("to_width", 32'(bus_if.err_timeout), 32'd0);
    record_starts(1, 40);
    chk("to_regrant_dist", 32'(rec_t[0] - t_err), 32'(GAP + 1));
    chk("to_regrant_gid", 32'(rec_gid[0]), 32'd1);
    chk("to_regrant_byte", 32'(rec_byte[0]), 32'h20);
    tx_dead = 1'b0;
    do_reset(1'b1);

    // Transmitter busy across reset release: no grant until busy falls
    rst_n = 1'b0; tm_active = 1'b0; force_busy = 1'b1;
    bus_if.tx_busy = 1'b1;
    bus_if.req_data = 32'hC300_0000;
    bus_if.req = 4'b1000;
    tick(); tick();
    rst_n = 1'b1;
    hold = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus_if.ack != '0 || bus_if.tx_start) hold++;
    end
    chk("busy_hold", 32'(hold), 32'd0);
    force_busy = 1'b0; bus_if.tx_busy = 1'b0; auto_drop = 1'b1;
    tick();
    chk("busy_rel_ack",   32'(bus_if.ack),      32'b1000);
    chk("busy_rel_start", 32'(bus_if.tx_start), 32'd1);
    chk("busy_rel_gid",   32'(bus_if.grant_id), 32'd3);
    chk("busy_rel_data",  32'(bus_if.tx_data),  32'hC3);
    wait_idle();

    // Reset while the frame is in progress, then 1001 grants requester 0
    do_reset(1'b1);
    auto_drop = 1'b1;
    bus_if.req_data = 32'h9900_005A;
    bus_if.req = 4'b0001;
    tick();
    chk("wd_ack", 32'(bus_if.ack), 32'b0001);
    for (int k = 0; k < 8; k++) tick();
    chk("wd_in_frame", 32'(bus_if.arb_busy), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("wd_rst_ack",   32'(bus_if.ack),         32'd0);
    chk("wd_rst_start", 32'(bus_if.tx_start),    32'd0);
    chk("wd_rst_err",   32'(bus_if.err_timeout), 32'd0);
    chk("wd_rst_busy",  32'(bus_if.arb_busy),    32'd0);
    chk("wd_rst_data",  32'(bus_if.tx_data),     32'd0);
    chk("wd_rst_gid",   32'(bus_if.grant_id),    32'd0);
    rst_n = 1'b1;
    bus_if.req = 4'b1001;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (bus_if.ack != '0) break;
    end
    chk("wd_post_ack", 32'(bus_if.ack), 32'b0001);
    chk("wd_post_byte", 32'(bus_if.tx_data), 32'h5A);
    bus_if.req = '0;
    wait_idle();

    // Randomized traffic against the model
    do_reset(1'b1);
    auto_drop = 1'b1;
    rand_mode = 1'b1;
    for (int k = 0; k < 3000; k++) tick();
    rand_mode = 1'b0;
    bus_if.req = '0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
